wb_bus_1xn: RTL and testbench
=============================

Name: wb_bus_1xn

Overview:
- Parametrised single-master to N-slave pipelined Wishbone B4 interconnect, placed between the picorv32_wb master and the peripheral set (ROM, RAMs, GPIO, UART, measure unit).
- Successor to the fixed crossbar instance. Adds:
  - a configurable outstanding-transaction limit;
  - an ordering guard when switching slaves;
  - bus errors for unmapped addresses;
  - a watchdog timeout that aborts hung slaves;
  - a captured error-address status.

Parameters:
- NS, 6, number of slaves.
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- SLAVE_ADDR, {NS{AW'h0}}, packed base addresses; slave i occupies bits [i*AW +: AW].
- SLAVE_MASK, {NS{AW'h0}}, packed masks, same packing; slave i matches when (adr & mask) == (base & mask).
- MAX_OUT, 4, maximum outstanding accepted strobes (1..15).
- TIMEOUT_CYCLES, 1023, cycles without ack/err before abort; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  synchronous active-high reset
- wbm_cyc_i  in  1  master cycle
- wbm_stb_i  in  1  master strobe
- wbm_we_i  in  1  write enable
- wbm_adr_i  in  AW  address
- wbm_dat_i  in  DW  write data
- wbm_sel_i  in  DW/8  byte select
- wbm_ack_o  out  1  acknowledge
- wbm_err_o  out  1  bus error
- wbm_stall_o  out  1  stall
- wbm_dat_o  out  DW  read data
- wbs_cyc_o  out  NS  per-slave cycle
- wbs_stb_o  out  NS  per-slave strobe
- wbs_we_o  out  1  broadcast write enable
- wbs_adr_o  out  AW  broadcast address
- wbs_dat_o  out  DW  broadcast write data
- wbs_sel_o  out  DW/8  broadcast select
- wbs_ack_i  in  NS  per-slave acknowledge
- wbs_err_i  in  NS  per-slave error
- wbs_stall_i  in  NS  per-slave stall
- wbs_dat_i  in  NS*DW  packed read data, slave i at [i*DW +: DW]
- err_adr_o  out  AW  address of the most recent errored request
- err_cause_o  out  2  0 none, 1 unmapped, 2 slave err, 3 timeout

Behaviour:

Clock and reset:
- One clock: wb_clk_i. Synchronous active-high reset: wb_rst_i.
- Reset state: all wbs_cyc_o/wbs_stb_o = 0; wbm_ack_o, wbm_err_o, wbm_stall_o = 0; err_adr_o = 0; err_cause_o = 0; outstanding count = 0; state IDLE; grant = 0.

Address decode:
- Combinational. Lowest matching index wins.
- No match while wbm_cyc_i & wbm_stb_i means the request is unmapped.

Request path:
- Zero added latency.
- wbs_stb_o[g] = wbm_stb_i & cycle-open & (decode == g) & ~blocked.
- Broadcast we/adr/dat/sel are driven straight through.
- Accept occurs when stb & ~wbm_stall_o.

Stall:
- wbm_stall_o = selected slave's stall | (count == MAX_OUT) | (count > 0 & decode != grant) | state ERR.

FSM states and transitions:
- IDLE: a mapped strobe is accepted → BUSY, grant = decode, count = 1. An unmapped strobe → ERR.
- BUSY: wbs_cyc_o[grant] held high.
  - count += accept, −= (ack | err) of grant; a simultaneous accept and ack leaves count unchanged.
  - Return to IDLE when count reaches 0 and there is no new accept.
  - A request to a different slave stalls until count == 0.
- ERR: one cycle.
  - wbm_err_o = 1 registered, one cycle after the offending strobe; no slave strobe is issued.
  - err_adr_o captures the address; err_cause_o = 1.
  - Next state IDLE.

Response path:
- wbm_ack_o = wbs_ack_i[grant] & BUSY, combinational.
- wbm_err_o = wbs_err_i[grant] & BUSY (sets err_cause_o = 2), or the registered ERR/timeout pulse.
- wbm_dat_o = wbs_dat_i[grant] slice.
- Acks from non-granted slaves are ignored.

Watchdog:
- Counter width $clog2(TIMEOUT_CYCLES+1). Cleared on any ack/err/accept; counts while BUSY with count > 0.
- On reaching TIMEOUT_CYCLES:
  - wbm_err_o pulses for 1 cycle;
  - err_cause_o = 3; err_adr_o = last accepted address;
  - wbs_cyc_o[grant] forced 0 for that cycle;
  - count = 0; state → IDLE.

Master abort:
- wbm_cyc_i low drops all wbs_cyc_o the same cycle, count = 0, state → IDLE. Late acks are ignored.

Reset mid-transfer:
- Identical to master abort, plus all outputs return to their reset values.

Decomposition:
- Package wb_pkg:
  - WB_AW/WB_DW constants;
  - wb_err_cause_e enum {ERR_NONE, ERR_UNMAPPED, ERR_SLAVE, ERR_TIMEOUT};
  - bus_state_e enum {ST_IDLE, ST_BUSY, ST_ERR}.
- Sub-module wb_addr_decode: combinational priority decoder.
  - Parameters NS, AW, SLAVE_ADDR, SLAVE_MASK.
  - Outputs a one-hot hit vector, an index, and a miss flag.

Test Plan:
- Single reads: NS=6, slave 2 base 0x02000000 mask 0xFFFFFFC0, read 0x02000004 with slave ack next cycle → wbm_ack_o high same cycle as slave ack, wbm_dat_o = slave 2 data, only wbs_stb_o[2] pulsed.
- Pipelining: 6 back-to-back strobes to RAM (slave 1) that does not ack, MAX_OUT=4 → 4 accepted, wbm_stall_o high on the 5th; after each ack one more is accepted; total acks = 6.
- Slave switch: 2 outstanding to slave 1, then a strobe to 0x03000000 → stall until both acks return; slave 3 strobe issued the cycle after count hits 0, never earlier.
- Unmapped: strobe to 0x0F000000 → no wbs_stb_o, wbm_err_o high exactly 1 cycle later, err_adr_o = 0x0F000000, err_cause_o = 1.
- Timeout: TIMEOUT_CYCLES=16, slave 4 never acks → wbm_err_o on cycle 16 after accept, wbs_cyc_o[4] low that cycle, err_cause_o = 3; the next request to slave 0 succeeds normally.
- Abort and reset: wbm_cyc_i dropped with 3 outstanding, then a stale ack from the old slave arrives → it does not reach wbm_ack_o. wb_rst_i asserted mid-burst → all outputs return to reset values next edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and enums for the single-master Wishbone interconnect.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_SLAVE    = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } wb_err_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/wb_addr_decode.sv
// Priority address decoder: lowest-index base/mask match wins, miss when none match.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the master address.
module wb_addr_decode #(
  parameter int                NS         = 6,
  parameter int                AW         = 32,
  parameter logic [NS*AW-1:0]  SLAVE_ADDR = '0,
  parameter logic [NS*AW-1:0]  SLAVE_MASK = '0,
  localparam int               IW         = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic [AW-1:0] i_adr,
  output logic [NS-1:0] o_hit,
  output logic [IW-1:0] o_idx,
  output logic          o_miss
);

  logic [NS-1:0] w_match;

  // Raw per-slave match: address bits under the mask equal the masked base
  always_comb begin
    w_match = '0;
    for (int i = 0; i < NS; i++) begin
      w_match[i] = ((i_adr & SLAVE_MASK[i*AW +: AW]) ==
                    (SLAVE_ADDR[i*AW +: AW] & SLAVE_MASK[i*AW +: AW]));
    end
  end

  // Walk from the top index down so the lowest matching slave is the last writer
  always_comb begin
    o_hit  = '0;
    o_idx  = '0;
    o_miss = 1'b1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_idx    = IW'(i);
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_bus_1xn.sv
// Single-master to NS-slave pipelined Wishbone interconnect with error/timeout handling.
// Latency: zero added on request and response paths; unmapped error one cycle after strobe.
// Backpressure: stall on slave stall, outstanding limit, slave switch with pending acks, ERR state.
module wb_bus_1xn
  import wb_pkg::*;
#(
  parameter int               NS             = 6,
  parameter int               AW             = WB_AW,
  parameter int               DW             = WB_DW,
  parameter logic [NS*AW-1:0] SLAVE_ADDR     = {NS{{AW{1'b0}}}},
  parameter logic [NS*AW-1:0] SLAVE_MASK     = {NS{{AW{1'b0}}}},
  parameter int               MAX_OUT        = 4,
  parameter int               TIMEOUT_CYCLES = 1023
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbm_cyc_i,
  input  logic               wbm_stb_i,
  input  logic               wbm_we_i,
  input  logic [AW-1:0]      wbm_adr_i,
  input  logic [DW-1:0]      wbm_dat_i,
  input  logic [DW/8-1:0]    wbm_sel_i,
  output logic               wbm_ack_o,
  output logic               wbm_err_o,
  output logic               wbm_stall_o,
  output logic [DW-1:0]      wbm_dat_o,
  output logic [NS-1:0]      wbs_cyc_o,
  output logic [NS-1:0]      wbs_stb_o,
  output logic               wbs_we_o,
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [DW/8-1:0]    wbs_sel_o,
  input  logic [NS-1:0]      wbs_ack_i,
  input  logic [NS-1:0]      wbs_err_i,
  input  logic [NS-1:0]      wbs_stall_i,
  input  logic [NS*DW-1:0]   wbs_dat_i,
  output logic [AW-1:0]      err_adr_o,
  output logic [1:0]         err_cause_o
);

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW = 4;
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
  localparam logic [WW-1:0] WDT_LAST = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          WDT_ON   = (TIMEOUT_CYCLES > 0);

  bus_state_e    r_state;
  logic [IW-1:0] r_grant;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wdt;
  logic [AW-1:0] r_last_adr;
  logic [AW-1:0] r_err_adr;
  wb_err_cause_e r_err_cause;

  logic [NS-1:0] w_dec_hit;
  logic [IW-1:0] w_dec_idx;
  logic          w_dec_miss;
  logic [NS-1:0] w_grant_oh;
  logic          w_cyc_open;
  logic          w_req;
  logic          w_busy;
  logic          w_blocked;
  logic          w_slv_stall;
  logic          w_issue;
  logic          w_accept;
  logic          w_unmapped;
  logic          w_resp_ack;
  logic          w_resp_err;
  logic          w_resp;
  logic          w_wdt_fire;

  wb_addr_decode #(
    .NS         (NS),
    .AW         (AW),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .i_adr  (wbm_adr_i),
    .o_hit  (w_dec_hit),
    .o_idx  (w_dec_idx),
    .o_miss (w_dec_miss)
  );

  // Reset behaves like a master abort for everything combinational
  assign w_cyc_open = wbm_cyc_i & ~wb_rst_i;
  assign w_req      = w_cyc_open & wbm_stb_i;
  assign w_busy     = (r_state == ST_BUSY);
  assign w_grant_oh = NS'(1) << r_grant;

  // Only the granted slave may answer; anything else is a stale or stray response
  assign w_resp_ack = w_busy & w_cyc_open & wbs_ack_i[r_grant];
  assign w_resp_err = w_busy & w_cyc_open & wbs_err_i[r_grant];
  assign w_resp     = w_resp_ack | w_resp_err;

  assign w_wdt_fire = WDT_ON & w_busy & w_cyc_open & (r_count != '0) & ~w_resp &
                      (r_wdt == WDT_LAST);

  // Ordering guard: a new target must wait until every response from the old one is back
  assign w_blocked = (r_count == MAX_CNT) |
                     ((r_count != '0) & (w_dec_miss | (w_dec_idx != r_grant))) |
                     (r_state == ST_ERR) | w_wdt_fire;

  assign w_slv_stall = ~w_dec_miss & wbs_stall_i[w_dec_idx];
  assign w_issue     = w_req & ~w_dec_miss & ~w_blocked;
  assign w_accept    = w_issue & ~w_slv_stall;
  assign w_unmapped  = w_req & w_dec_miss & ~w_blocked & (r_state == ST_IDLE);

  assign wbm_stall_o = w_req & (w_slv_stall | w_blocked);
  assign wbs_stb_o   = w_issue ? w_dec_hit : '0;
  assign wbs_cyc_o   = ((w_busy & w_cyc_open & ~w_wdt_fire) ? w_grant_oh : '0) | wbs_stb_o;
  assign wbs_we_o    = wbm_we_i;
  assign wbs_adr_o   = wbm_adr_i;
  assign wbs_dat_o   = wbm_dat_i;
  assign wbs_sel_o   = wbm_sel_i;

  assign wbm_ack_o   = w_resp_ack;
  assign wbm_err_o   = w_resp_err | w_wdt_fire | (r_state == ST_ERR);
  assign wbm_dat_o   = wbs_dat_i[r_grant*DW +: DW];
  assign err_adr_o   = r_err_adr;
  assign err_cause_o = r_err_cause;

  // Bus FSM: grant ownership and outstanding-strobe bookkeeping
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_count <= '0;
    end else if (!w_cyc_open) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_BUSY;
            r_grant <= w_dec_idx;
            r_count <= CW'(1);
          end else if (w_unmapped) begin
            r_state <= ST_ERR;
          end
        end
        ST_BUSY: begin
          if (w_wdt_fire) begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end else if (w_accept && !w_resp) begin
            r_count <= r_count + CW'(1);
          end else if (!w_accept && w_resp) begin
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Error status capture; last accepted address is kept for timeout/slave-error reports
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_last_adr  <= '0;
      r_err_adr   <= '0;
      r_err_cause <= ERR_NONE;
    end else begin
      if (w_accept) begin
        r_last_adr <= wbm_adr_i;
      end
      if (w_unmapped) begin
        r_err_adr   <= wbm_adr_i;
        r_err_cause <= ERR_UNMAPPED;
      end else if (w_wdt_fire) begin
        r_err_adr   <= r_last_adr;
        r_err_cause <= ERR_TIMEOUT;
      end else if (w_resp_err) begin
        r_err_adr   <= r_last_adr;
        r_err_cause <= ERR_SLAVE;
      end
    end
  end

  // Watchdog: counts silent BUSY cycles, restarts on any accept or response
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wdt <= '0;
    end else if (!w_busy || !w_cyc_open || w_accept || w_resp || w_wdt_fire) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + WW'(1);
    end
  end

endmodule

// File: tb/tb_wb_bus_1xn.sv
// Self-checking bench for wb_bus_1xn against a table-driven address map and transaction model.
// Latency: n/a.
// Backpressure: slave stall and ack timing randomised per scenario.
module tb_wb_bus_1xn;

  localparam int NS      = 6;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAX_OUT = 4;
  localparam int TMO     = 16;
  localparam logic [NS*AW-1:0] P_ADDR = {32'h05000000, 32'h04000000, 32'h03000000,
                                         32'h02000000, 32'h01000000, 32'h00000000};
  localparam logic [NS*AW-1:0] P_MASK = {32'hFF000000, 32'hFF000000, 32'hFF000000,
                                         32'hFFFFFFC0, 32'hFF000000, 32'hFF000000};

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [AW-1:0]     wbm_adr_i;
  logic [DW-1:0]     wbm_dat_i;
  logic [DW/8-1:0]   wbm_sel_i;
  logic              wbm_ack_o, wbm_err_o, wbm_stall_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [NS-1:0]     wbs_cyc_o, wbs_stb_o;
  logic              wbs_we_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic [NS-1:0]     wbs_ack_i, wbs_err_i, wbs_stall_i;
  logic [NS*DW-1:0]  wbs_dat_i;
  logic [AW-1:0]     err_adr_o;
  logic [1:0]        err_cause_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] base_tab [NS] = '{32'h00000000, 32'h01000000, 32'h02000000,
                                 32'h03000000, 32'h04000000, 32'h05000000};
  logic [31:0] mask_tab [NS] = '{32'hFF000000, 32'hFF000000, 32'hFFFFFFC0,
                                 32'hFF000000, 32'hFF000000, 32'hFF000000};

  wb_bus_1xn #(
    .NS(NS), .AW(AW), .DW(DW), .SLAVE_ADDR(P_ADDR), .SLAVE_MASK(P_MASK),
    .MAX_OUT(MAX_OUT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_stall_o(wbm_stall_o),
    .wbm_dat_o(wbm_dat_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_we_o(wbs_we_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_stall_i(wbs_stall_i), .wbs_dat_i(wbs_dat_i),
    .err_adr_o(err_adr_o), .err_cause_o(err_cause_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Reference map: first table entry whose masked bits match, -1 when none
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_tab[i]) == (base_tab[i] & mask_tab[i])) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr(input int s);
    if (s == 2) return 32'h02000000 | ($urandom & 32'h0000003C);
    return (32'(s) << 24) | ($urandom & 32'h00FFFFFC);
  endfunction

  function automatic logic [NS-1:0] onehot(input int s);
    logic [NS-1:0] v;
    v = '0;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0; wbm_adr_i = '0; wbm_dat_i = '0;
    wbm_sel_i = '0; wbs_ack_i = '0; wbs_err_i = '0; wbs_stall_i = '0; wbs_dat_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wb_rst_i = 1;
    step(); step();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = 32'h02000004; wbs_ack_i = '1;
    step();
    #1;
    n_checks++; if (wbs_cyc_o !== '0) $display("FAIL reset_cyc got=%b exp=0", wbs_cyc_o); else n_pass++;
    n_checks++; if (wbs_stb_o !== '0) $display("FAIL reset_stb got=%b exp=0", wbs_stb_o); else n_pass++;
    n_checks++; if ({wbm_ack_o, wbm_err_o, wbm_stall_o} !== 3'b000)
      $display("FAIL reset_ack_err_stall got=%b exp=000", {wbm_ack_o, wbm_err_o, wbm_stall_o}); else n_pass++;
    n_checks++; if (err_adr_o !== '0 || err_cause_o !== 2'd0)
      $display("FAIL reset_err_status got=%h/%0d exp=0/0", err_adr_o, err_cause_o); else n_pass++;
    idle_inputs();
    wb_rst_i = 0;
    step();
  endtask

  task automatic test_single_read(input int iters);
    for (int it = 0; it < iters; it++) begin
      int s, other, nstall, ndly;
      logic [31:0] a, wd, rd;
      logic [NS-1:0] oh;
      logic exp_st;
      s      = $urandom_range(0, NS - 1);
      a      = rand_addr(s);
      oh     = onehot(ref_slave(a));
      other  = (s + 1) % NS;
      nstall = $urandom_range(0, 2);
      ndly   = $urandom_range(0, 3);
      wd     = $urandom;
      wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1'($urandom_range(0, 1));
      wbm_adr_i = a; wbm_dat_i = wd; wbm_sel_i = 4'($urandom);
      for (int c = 0; c <= nstall; c++) begin
        exp_st = (c < nstall);
        wbs_stall_i = exp_st ? oh : '0;
        #1;
        n_checks++; if (wbs_stb_o !== oh) $display("FAIL single_stb got=%b exp=%b", wbs_stb_o, oh); else n_pass++;
        n_checks++; if (wbm_stall_o !== exp_st) $display("FAIL single_stall got=%b exp=%b", wbm_stall_o, exp_st); else n_pass++;
        if (!exp_st) begin
          n_checks++; if (wbs_adr_o !== a || wbs_dat_o !== wd)
            $display("FAIL single_bcast got=%h/%h exp=%h/%h", wbs_adr_o, wbs_dat_o, a, wd); else n_pass++;
        end
        step();
      end
      wbm_stb_i = 0; wbs_stall_i = '0;
      for (int d = 0; d <= ndly; d++) begin
        rd = $urandom;
        wbs_dat_i = {NS*DW{1'b1}};
        wbs_dat_i[s*DW +: DW] = rd;
        wbs_ack_i = (d == ndly) ? oh : onehot(other);
        #1;
        n_checks++; if (wbs_cyc_o !== oh) $display("FAIL single_cyc_hold got=%b exp=%b", wbs_cyc_o, oh); else n_pass++;
        n_checks++; if (wbm_ack_o !== (d == ndly)) $display("FAIL single_ack got=%b exp=%b", wbm_ack_o, (d == ndly)); else n_pass++;
        if (d == ndly) begin
          n_checks++; if (wbm_dat_o !== rd) $display("FAIL single_rdata got=%h exp=%h", wbm_dat_o, rd); else n_pass++;
        end
        step();
      end
      wbs_ack_i = '0; wbm_cyc_i = 0;
      #1;
      n_checks++; if (wbs_cyc_o !== '0 || wbm_ack_o !== 1'b0)
        $display("FAIL single_done got=%b/%b exp=0/0", wbs_cyc_o, wbm_ack_o); else n_pass++;
      step();
    end
  endtask

  task automatic test_pipeline();
    int sent, outst, acks, cyc_no, first_stall_sent;
    logic exp_stall, ack_now, sending;
    logic [31:0] rd;
    sent = 0; outst = 0; acks = 0; cyc_no = 0; first_stall_sent = -1;
    while (acks < 6 && cyc_no < 100) begin
      sending = (sent < 6);
      ack_now = (outst > 0) && (cyc_no >= 6) && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      wbm_cyc_i = 1; wbm_stb_i = sending; wbm_we_i = 0;
      wbm_adr_i = 32'h01000000 + 32'(sent * 4);
      wbs_dat_i = '0; wbs_dat_i[1*DW +: DW] = rd;
      wbs_ack_i = ack_now ? onehot(1) : '0;
      #1;
      exp_stall = sending && (outst == MAX_OUT);
      if (exp_stall && first_stall_sent < 0) first_stall_sent = sent;
      n_checks++; if (wbm_stall_o !== exp_stall) $display("FAIL pipe_stall cyc=%0d got=%b exp=%b", cyc_no, wbm_stall_o, exp_stall); else n_pass++;
      n_checks++; if (wbs_stb_o !== ((sending && !exp_stall) ? onehot(1) : '0))
        $display("FAIL pipe_stb cyc=%0d got=%b", cyc_no, wbs_stb_o); else n_pass++;
      n_checks++; if (wbm_ack_o !== ack_now) $display("FAIL pipe_ack cyc=%0d got=%b exp=%b", cyc_no, wbm_ack_o, ack_now); else n_pass++;
      if (ack_now) begin
        n_checks++; if (wbm_dat_o !== rd) $display("FAIL pipe_rdata got=%h exp=%h", wbm_dat_o, rd); else n_pass++;
      end
      if (sending && !exp_stall) begin sent++; outst++; end
      if (ack_now) begin outst--; acks++; end
      cyc_no++;
      step();
    end
    idle_inputs();
    #1;
    n_checks++; if (acks !== 6) $display("FAIL pipe_total_acks got=%0d exp=6", acks); else n_pass++;
    n_checks++; if (first_stall_sent !== MAX_OUT) $display("FAIL pipe_first_stall got=%0d exp=%0d", first_stall_sent, MAX_OUT); else n_pass++;
    n_checks++; if (wbs_cyc_o !== '0) $display("FAIL pipe_idle_cyc got=%b exp=0", wbs_cyc_o); else n_pass++;
    step();
  endtask

  task automatic test_slave_switch();
    int outst, guard;
    logic ack_now, exp_stall, issued;
    wbm_cyc_i = 1; wbm_stb_i = 1;
    for (int k = 0; k < 2; k++) begin
      wbm_adr_i = rand_addr(1);
      #1;
      n_checks++; if (wbs_stb_o !== onehot(1)) $display("FAIL switch_first_stb got=%b", wbs_stb_o); else n_pass++;
      step();
    end
    outst = 2; guard = 0; issued = 0;
    wbm_adr_i = 32'h03000000;
    while (!issued && guard < 40) begin
      ack_now = (outst > 0) && ($urandom_range(0, 2) == 0);
      wbs_ack_i = ack_now ? onehot(1) : '0;
      #1;
      exp_stall = (outst > 0);
      n_checks++; if (wbm_stall_o !== exp_stall) $display("FAIL switch_stall got=%b exp=%b", wbm_stall_o, exp_stall); else n_pass++;
      n_checks++; if (wbs_stb_o !== (exp_stall ? '0 : onehot(3))) $display("FAIL switch_stb got=%b outst=%0d", wbs_stb_o, outst); else n_pass++;
      n_checks++; if (wbm_ack_o !== ack_now) $display("FAIL switch_ack got=%b exp=%b", wbm_ack_o, ack_now); else n_pass++;
      if (!exp_stall) issued = 1;
      if (ack_now) outst--;
      guard++;
      step();
    end
    n_checks++; if (!issued) $display("FAIL switch_issue_timeout got=0 exp=1"); else n_pass++;
    wbm_stb_i = 0; wbs_ack_i = onehot(3);
    #1;
    n_checks++; if (wbm_ack_o !== 1'b1) $display("FAIL switch_new_ack got=%b exp=1", wbm_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_unmapped();
    logic [31:0] ua [3];
    ua[0] = 32'h0F000000;
    ua[1] = 32'h02000040;
    ua[2] = {8'($urandom_range(6, 255)), 24'($urandom)};
    for (int k = 0; k < 3; k++) begin
      wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = ua[k];
      #1;
      n_checks++; if (wbs_stb_o !== '0 || wbs_cyc_o !== '0 || wbm_err_o !== 1'b0)
        $display("FAIL unmap_no_stb got=%b/%b/%b exp=0/0/0", wbs_stb_o, wbs_cyc_o, wbm_err_o); else n_pass++;
      step();
      wbm_stb_i = 0;
      #1;
      n_checks++; if (wbm_err_o !== 1'b1) $display("FAIL unmap_err got=%b exp=1", wbm_err_o); else n_pass++;
      n_checks++; if (err_adr_o !== ua[k] || err_cause_o !== 2'd1)
        $display("FAIL unmap_status got=%h/%0d exp=%h/1", err_adr_o, err_cause_o, ua[k]); else n_pass++;
      step();
      #1;
      n_checks++; if (wbm_err_o !== 1'b0) $display("FAIL unmap_err_pulse got=%b exp=0", wbm_err_o); else n_pass++;
      idle_inputs();
      step();
    end
  endtask

  task automatic test_slave_err();
    logic [31:0] a;
    a = rand_addr(5);
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = a;
    step();
    wbm_stb_i = 0; wbs_err_i = onehot(5);
    #1;
    n_checks++; if (wbm_err_o !== 1'b1 || wbm_ack_o !== 1'b0)
      $display("FAIL slverr_resp got=%b/%b exp=1/0", wbm_err_o, wbm_ack_o); else n_pass++;
    step();
    wbs_err_i = '0;
    #1;
    n_checks++; if (err_cause_o !== 2'd2 || err_adr_o !== a)
      $display("FAIL slverr_status got=%0d/%h exp=2/%h", err_cause_o, err_adr_o, a); else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    logic [31:0] a;
    a = rand_addr(4);
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = a;
    step();
    wbm_stb_i = 0;
    for (int k = 1; k <= TMO; k++) begin
      #1;
      n_checks++; if (wbm_err_o !== (k == TMO)) $display("FAIL tmo_err k=%0d got=%b exp=%b", k, wbm_err_o, (k == TMO)); else n_pass++;
      n_checks++; if (wbs_cyc_o !== ((k == TMO) ? '0 : onehot(4))) $display("FAIL tmo_cyc k=%0d got=%b", k, wbs_cyc_o); else n_pass++;
      step();
    end
    #1;
    n_checks++; if (wbm_err_o !== 1'b0 || err_cause_o !== 2'd3 || err_adr_o !== a)
      $display("FAIL tmo_status got=%b/%0d/%h exp=0/3/%h", wbm_err_o, err_cause_o, err_adr_o, a); else n_pass++;
    step();
    wbm_stb_i = 1; wbm_adr_i = rand_addr(0);
    #1;
    n_checks++; if (wbs_stb_o !== onehot(0) || wbm_stall_o !== 1'b0)
      $display("FAIL tmo_recover_stb got=%b/%b", wbs_stb_o, wbm_stall_o); else n_pass++;
    step();
    wbm_stb_i = 0; wbs_ack_i = onehot(0);
    #1;
    n_checks++; if (wbm_ack_o !== 1'b1) $display("FAIL tmo_recover_ack got=%b exp=1", wbm_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_abort();
    wbm_cyc_i = 1; wbm_stb_i = 1;
    for (int k = 0; k < 3; k++) begin
      wbm_adr_i = rand_addr(0);
      #1;
      n_checks++; if (wbs_stb_o !== onehot(0)) $display("FAIL abort_fill_stb got=%b", wbs_stb_o); else n_pass++;
      step();
    end
    wbm_cyc_i = 0; wbm_stb_i = 0;
    #1;
    n_checks++; if (wbs_cyc_o !== '0) $display("FAIL abort_cyc_drop got=%b exp=0", wbs_cyc_o); else n_pass++;
    step();
    wbs_ack_i = onehot(0);
    #1;
    n_checks++; if (wbm_ack_o !== 1'b0) $display("FAIL abort_stale_ack got=%b exp=0", wbm_ack_o); else n_pass++;
    step();
    wbm_cyc_i = 1;
    #1;
    n_checks++; if (wbm_ack_o !== 1'b0 || wbs_cyc_o !== '0)
      $display("FAIL abort_stale_ack_reopen got=%b/%b exp=0/0", wbm_ack_o, wbs_cyc_o); else n_pass++;
    step();
    wbs_ack_i = '0; wbm_stb_i = 1; wbm_adr_i = rand_addr(0);
    #1;
    n_checks++; if (wbm_stall_o !== 1'b0 || wbs_stb_o !== onehot(0))
      $display("FAIL abort_restart got=%b/%b", wbm_stall_o, wbs_stb_o); else n_pass++;
    step();
    wbm_stb_i = 0; wbs_ack_i = onehot(0);
    #1;
    n_checks++; if (wbm_ack_o !== 1'b1) $display("FAIL abort_restart_ack got=%b exp=1", wbm_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    wbm_cyc_i = 1; wbm_stb_i = 1;
    for (int k = 0; k < 2; k++) begin
      wbm_adr_i = rand_addr(2);
      step();
    end
    wb_rst_i = 1; wbs_ack_i = '1; wbs_err_i = '1;
    step();
    #1;
    n_checks++; if (wbs_cyc_o !== '0 || wbs_stb_o !== '0)
      $display("FAIL rstmid_slave got=%b/%b exp=0/0", wbs_cyc_o, wbs_stb_o); else n_pass++;
    n_checks++; if ({wbm_ack_o, wbm_err_o, wbm_stall_o} !== 3'b000)
      $display("FAIL rstmid_master got=%b exp=000", {wbm_ack_o, wbm_err_o, wbm_stall_o}); else n_pass++;
    n_checks++; if (err_adr_o !== '0 || err_cause_o !== 2'd0)
      $display("FAIL rstmid_status got=%h/%0d exp=0/0", err_adr_o, err_cause_o); else n_pass++;
    idle_inputs();
    wb_rst_i = 0;
    step();
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_adr_i = rand_addr(3);
    #1;
    n_checks++; if (wbs_stb_o !== onehot(3)) $display("FAIL rstmid_after_stb got=%b", wbs_stb_o); else n_pass++;
    step();
    wbm_stb_i = 0; wbs_ack_i = onehot(3);
    #1;
    n_checks++; if (wbm_ack_o !== 1'b1) $display("FAIL rstmid_after_ack got=%b exp=1", wbm_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    wb_rst_i = 1;
    idle_inputs();
    test_reset();
    test_single_read(8);
    test_pipeline();
    test_slave_switch();
    test_unmapped();
    test_slave_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
